// File: rtl/bs_pkg.sv
// -----------------------------------------------------------------------------
// bs_pkg
//   Definitions shared by the program sequencer and the bit-serial decoder.
//   - opcode_t    : 3-bit opcode encoding. ADD decodes as 10?, so both codes
//                   are named to keep every 3-bit value a legal enum member.
//   - is_ctrl_op  : 1 for the control opcodes (NOP, STALL, WAIT). On these
//                   the decoder clears its bit count when it advances.
//   - BIT_LAST    : last bit index of a serial operation.
// -----------------------------------------------------------------------------
package bs_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_STALL   = 3'b001,
        OP_MUL_YD  = 3'b010,
        OP_MUL_X1D = 3'b011,
        OP_ADD     = 3'b100,
        OP_ADD_ALT = 3'b101,
        OP_WAIT    = 3'b110,
        OP_LDX     = 3'b111
    } opcode_t;

    localparam logic [2:0] BIT_LAST = 3'd7;

    // Control ops do not run the full 8-bit serial sequence, so the bit
    // counter has to be reloaded when the program leaves one of them.
    function automatic logic is_ctrl_op(input opcode_t op);
        logic ctrl;
        case (op)
            OP_NOP, OP_STALL, OP_WAIT: ctrl = 1'b1;
            default:                   ctrl = 1'b0;
        endcase
        return ctrl;
    endfunction

endpackage : bs_pkg

// File: rtl/start_debounce.sv
// -----------------------------------------------------------------------------
// start_debounce
//   Brings the raw start switch into the i_clk domain with a two-flop
//   synchroniser, then debounces it: o_clean only follows the synchronised
//   level after it has differed from o_clean for DEB_CYC consecutive cycles.
//   Input-to-output latency is 2 + DEB_CYC cycles; any excursion shorter than
//   DEB_CYC cycles is filtered out completely.
//
// Ports
//   i_clk    in  1  system clock
//   i_rst_n  in  1  asynchronous active-low reset
//   i_raw    in  1  raw switch, asynchronous to i_clk
//   o_clean  out 1  synchronised, debounced level (registered)
// -----------------------------------------------------------------------------
module start_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_clean
);

    // Counter only has to reach DEB_CYC-1; keep at least one bit for DEB_CYC=1.
    localparam int              CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             meta_q;
    logic             sync_q;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter measures how long the synchronised level has disagreed with
    // the current output. Agreement clears it, so a glitch restarts the count.
    // Reaching CNT_LAST while still disagreeing means DEB_CYC stable cycles:
    // flip the output and clear the count in the same edge.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = ~clean_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= i_raw;
            sync_q  <= meta_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_clean = clean_q;

endmodule : start_debounce

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Program sequencer sitting directly in front of the bit-serial decoder.
//   Holds the program counter and a parameterised ROM of 3-bit opcodes,
//   presents the current opcode, and supplies the decoder's next bit index.
//   Advancing to the next word takes effect on the strobe edge itself, so the
//   decoder sees the new opcode in the very next cycle (no bubble).
//
// Parameters
//   PROG_LEN   number of program words (>= 2)
//   LOOP_ADDR  PC loaded after the last word executes
//   DEB_CYC    stable cycles needed to change o_start (>= 1)
//   PROGRAM    packed ROM image, word k at bits [3k+2:3k]
//   PC_W       derived program counter width
//
// Ports
//   i_clk         in   1     system clock, rising edge
//   i_rst_n       in   1     asynchronous active-low reset (release is
//                            expected to be synchronous to i_clk upstream)
//   i_start_raw   in   1     raw start switch, asynchronous
//   i_pcincr      in   1     decoder strobe: current instruction completes
//   i_hold        in   1     single-step freeze
//   o_instr       out  3     opcode presented to the decoder (registered)
//   o_start       out  1     synchronised + debounced start
//   o_data_count  out  3     next bit index for the decoder's count register
//   o_pc          out  PC_W  address of the word on o_instr
//   o_wrap        out  1     one-cycle pulse after PC reloads LOOP_ADDR
//
// Strobe / hold protocol
//   An advance happens on a rising edge where i_pcincr=1 and i_hold=0. While
//   i_hold=1 the PC, opcode and bit count are frozen and i_pcincr is dropped
//   (not queued); the decoder is responsible for re-asserting it after the
//   hold is released. The start path is never held.
// -----------------------------------------------------------------------------
module instr_sequencer
    import bs_pkg::*;
#(
    parameter int                    PROG_LEN  = 16,
    parameter int                    LOOP_ADDR = 0,
    parameter int                    DEB_CYC   = 4,
    parameter logic [3*PROG_LEN-1:0] PROGRAM   = {PROG_LEN{3'b001}},
    localparam int                   PC_W      = $clog2(PROG_LEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start_raw,
    input  logic            i_pcincr,
    input  logic            i_hold,
    output logic [2:0]      o_instr,
    output logic            o_start,
    output logic [2:0]      o_data_count,
    output logic [PC_W-1:0] o_pc,
    output logic            o_wrap
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W-1:0] PC_LOOP = PC_W'(LOOP_ADDR);

    // -------------------------------------------------------------------------
    // Program ROM, unpacked from the parameter image. Only indices below
    // PROG_LEN are ever addressed because the PC wraps at PC_LAST.
    // -------------------------------------------------------------------------
    opcode_t rom [PROG_LEN];

    for (genvar k = 0; k < PROG_LEN; k++) begin : g_rom
        assign rom[k] = opcode_t'(PROGRAM[3*k +: 3]);
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_W-1:0] pc_q, pc_d;
    opcode_t         instr_q, instr_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            wrap_q, wrap_d;

    logic [PC_W-1:0] pc_next;
    logic            at_last;
    logic            advance;

    assign at_last = (pc_q == PC_LAST);
    assign pc_next = at_last ? PC_LOOP : pc_q + 1'b1;
    assign advance = i_pcincr & ~i_hold;

    // -------------------------------------------------------------------------
    // Next-state logic
    //   The opcode register is loaded from the ROM at pc_next on the advance
    //   edge, which is what removes the bubble between instructions.
    //   The bit counter free-runs modulo 8. Serial ops advance at count 7 so
    //   the natural wrap already gives 0; control ops advance at arbitrary
    //   counts while the decoder clears its own count, so the counter is
    //   reloaded to 1 to stay one step ahead of the decoder.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (!i_hold) begin
            cnt_d = (cnt_q == BIT_LAST) ? 3'd0 : cnt_q + 3'd1;

            if (advance) begin
                pc_d    = pc_next;
                instr_d = rom[pc_next];
                wrap_d  = at_last;
                if (is_ctrl_op(instr_q)) begin
                    cnt_d = 3'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q    <= '0;
            instr_q <= rom[0];
            cnt_q   <= 3'd1;
            wrap_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Start switch conditioning
    // -------------------------------------------------------------------------
    start_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_start_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_start_raw),
        .o_clean (o_start)
    );

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign o_pc         = pc_q;
    assign o_instr      = instr_q;
    assign o_data_count = cnt_q;
    assign o_wrap       = wrap_q;

endmodule : instr_sequencer

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Driver applies inputs at the falling edge and pushes the expected
//   post-edge outputs (from a behavioural model) into exp_q; a monitor pops
//   and compares one entry per rising edge. Asynchronous reset behaviour is
//   checked directly between edges.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PROG_LEN  = 8;
    localparam int LOOP_ADDR = 1;
    localparam int DEB_CYC   = 4;
    localparam int PC_W      = 3;
    localparam int W         = 11;

    // word7 .. word0
    localparam logic [3*PROG_LEN-1:0] PROGRAM =
        {3'b101, 3'b011, 3'b010, 3'b001, 3'b111, 3'b100, 3'b110, 3'b000};

    // Reference copy of the program, word 0 first.
    logic [2:0] prog [PROG_LEN] = '{3'd0, 3'd6, 3'd4, 3'd7, 3'd1, 3'd2, 3'd3, 3'd5};

    // ---------------------------------------------------------------- clock/reset
    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_raw;
    logic            pcincr;
    logic            hold;
    logic [2:0]      instr;
    logic            start;
    logic [2:0]      data_count;
    logic [PC_W-1:0] pc;
    logic            wrap;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PROG_LEN  (PROG_LEN),
        .LOOP_ADDR (LOOP_ADDR),
        .DEB_CYC   (DEB_CYC),
        .PROGRAM   (PROGRAM)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_raw  (start_raw),
        .i_pcincr     (pcincr),
        .i_hold       (hold),
        .o_instr      (instr),
        .o_start      (start),
        .o_data_count (data_count),
        .o_pc         (pc),
        .o_wrap       (wrap)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------- model
    int m_pc;
    int m_cnt;
    bit m_wrap;
    bit m_start;
    bit raw_hist[$];   // raw level present before each rising edge since reset

    function automatic bit is_ctrl(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
    endfunction

    task automatic model_reset();
        m_pc    = 0;
        m_cnt   = 1;
        m_wrap  = 0;
        m_start = 0;
        raw_hist.delete();
        for (int i = 0; i < DEB_CYC + 2; i++) raw_hist.push_back(1'b0);
    endtask

    // Effect of one rising edge on the model.
    task automatic model_edge(input bit inc, input bit hld, input bit raw);
        bit all_diff;
        if (!hld) begin
            if (inc) begin
                m_cnt  = is_ctrl(prog[m_pc]) ? 1 : (m_cnt + 1) % 8;
                m_wrap = (m_pc == PROG_LEN - 1);
                m_pc   = m_wrap ? LOOP_ADDR : m_pc + 1;
            end else begin
                m_cnt  = (m_cnt + 1) % 8;
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
        // The synchronised level seen at an edge is the raw level from two
        // edges earlier; the output flips once the last DEB_CYC of those all
        // disagree with it.
        raw_hist.push_back(raw);
        all_diff = 1;
        for (int k = 0; k < DEB_CYC; k++)
            if (raw_hist[raw_hist.size() - 3 - k] == m_start) all_diff = 0;
        if (all_diff) m_start = !m_start;
        if (raw_hist.size() > 32) void'(raw_hist.pop_front());
    endtask

    // ---------------------------------------------------------------- driver
    task automatic step(input bit inc, input bit hld, input bit raw);
        pcincr    = inc;
        hold      = hld;
        start_raw = raw;
        if (!rst_n) model_reset();
        else        model_edge(inc, hld, raw);
        exp_q.push_back({3'(m_pc), prog[m_pc], 3'(m_cnt), m_wrap, m_start});
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " pc"}, int'(pc), 0);
        check_val({tag, " instr"}, int'(instr), int'(prog[0]));
        check_val({tag, " data_count"}, int'(data_count), 1);
        check_val({tag, " start"}, int'(start), 0);
        check_val({tag, " wrap"}, int'(wrap), 0);
    endtask

    // Assert reset between edges and check that outputs drop immediately.
    task automatic async_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        for (int i = 0; i < cycles; i++) step(0, 0, start_raw);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset_release");
    endtask

    // Behaves like the decoder: control ops finish after a short random wait,
    // serial ops finish when the presented bit index is 7.
    task automatic run_decoder(input int n_instr, input bit raw);
        for (int n = 0; n < n_instr; n++) begin
            if (is_ctrl(prog[m_pc])) begin
                repeat ($urandom_range(0, 3)) step(0, 0, raw);
            end else begin
                for (int g = 0; g < 16 && m_cnt != 7; g++) step(0, 0, raw);
            end
            step(1, 0, raw);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {pc, instr, data_count, wrap, start};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle @%0t: actual pc=%0d instr=%0d cnt=%0d wrap=%0b start=%0b required pc=%0d instr=%0d cnt=%0d wrap=%0b start=%0b",
                             $time, a[10:8], a[7:5], a[4:2], a[1], a[0],
                             e[10:8], e[7:5], e[4:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------------------------------------------------------- watchdog
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int  raw_left;
        bit  raw_lvl;

        rst_n     = 1'b0;
        start_raw = 1'b0;
        pcincr    = 1'b0;
        hold      = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        repeat (3) step(0, 0, 0);

        // Reset release: values before any clock edge.
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset");

        // NOP advance, then a decoder-paced run through the wrap.
        step(1, 0, 0);
        run_decoder(12, 0);

        // Hold with strobe held high: frozen, strobe dropped, then resume.
        repeat (3) step(1, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        run_decoder(4, 0);

        // Debounce: short pulse filtered, long level passes.
        repeat (3) step(0, 0, 1);
        repeat (12) step(0, 0, 0);
        repeat (10) step(0, 0, 1);
        repeat (4) step(0, 0, 1);
        repeat (2) step(0, 0, 0);
        repeat (12) step(0, 0, 0);

        // Reset in the middle of MUL at word 5, bit index 3.
        for (int g = 0; g < 32 && m_pc != 5; g++) step(1, 0, 0);
        for (int g = 0; g < 16 && m_cnt != 3; g++) step(0, 0, 0);
        check_val("reach_mul_pc", m_pc, 5);
        async_reset(2);
        run_decoder(6, 0);

        // Randomised traffic.
        raw_lvl  = 0;
        raw_left = $urandom_range(1, 10);
        for (int i = 0; i < 2500; i++) begin
            if (raw_left == 0) begin
                raw_lvl  = !raw_lvl;
                raw_left = $urandom_range(1, 10);
            end
            raw_left--;
            if ($urandom_range(0, 399) == 0) begin
                async_reset($urandom_range(1, 3));
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, raw_lvl);
            end
        end
        step(0, 0, raw_lvl);

        // Drain.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check_val("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_sequencer
